// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between instruction and data ports onto one RAM.
// Sequences IDLE/ISSUE/WAIT/RESP with Avalon-style waitrequest per port.
module mem_port_arbiter #(
  parameter int MEM_BYTES   = 4096,
  parameter bit FIRST_GRANT = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [3:0]  d_byteenable,
  input  logic [31:0] d_writedata,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic        bus_error,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic        grant;
  logic        last_grant;
  logic        is_wr;
  logic        req_i;
  logic        req_d;
  logic        sel;
  logic        sel_wr;
  logic        in_range;
  logic [31:0] sel_addr;
  logic [3:0]  sel_be;

  always_comb begin
    req_i    = i_read;
    req_d    = d_read | d_write;
    sel      = (req_i & req_d) ? ~last_grant : req_d;
    sel_addr = sel ? d_address : i_address;
    sel_be   = sel ? d_byteenable : 4'hf;
    sel_wr   = sel & d_write;
    // 33-bit sum so addresses near 2^32 cannot wrap into range
    in_range = ({1'b0, sel_addr} + 33'd3) < 33'(MEM_BYTES);
  end

  assign i_waitrequest =
    i_read & ~((state == RESP) & ~grant);
  assign d_waitrequest =
    (d_read | d_write) & ~((state == RESP) & grant);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      grant          <= 1'b0;
      last_grant     <= ~FIRST_GRANT;
      is_wr          <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= 32'h0;
      mem_byteenable <= 4'h0;
      mem_writedata  <= 32'h0;
      i_readdata     <= 32'h0;
      d_readdata     <= 32'h0;
      bus_error      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_i | req_d) begin
            grant      <= sel;
            last_grant <= sel;
            is_wr      <= sel_wr;
            if (in_range) begin
              state          <= ISSUE;
              mem_address    <= sel_addr;
              mem_byteenable <= sel_be;
              mem_read       <= ~sel_wr;
              mem_write      <= sel_wr;
              if (sel) begin
                mem_writedata <= d_writedata;
              end
            end else begin
              state     <= RESP;
              bus_error <= 1'b1;
              if (!sel_wr) begin
                if (sel) d_readdata <= 32'h0;
                else     i_readdata <= 32'h0;
              end
            end
          end
        end
        ISSUE: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          state     <= is_wr ? RESP : WAIT;
        end
        WAIT: begin
          if (grant) d_readdata <= mem_readdata;
          else       i_readdata <= mem_readdata;
          state <= RESP;
        end
        RESP: begin
          bus_error <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-RAM model plus transaction-level
// reference of memory contents, latency and round-robin order.
module tb_mem_port_arbiter;
  localparam int MEMB = 4096;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_read = 1'b0;
  logic [31:0] i_address = '0;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_address = '0;
  logic [3:0]  d_byteenable = '0;
  logic [31:0] d_writedata = '0;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic        bus_error;
  logic [31:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MEM_BYTES(MEMB),
    .FIRST_GRANT(1'b0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_read(i_read),
    .i_address(i_address),
    .i_waitrequest(i_waitrequest),
    .i_readdata(i_readdata),
    .d_read(d_read),
    .d_write(d_write),
    .d_address(d_address),
    .d_byteenable(d_byteenable),
    .d_writedata(d_writedata),
    .d_waitrequest(d_waitrequest),
    .d_readdata(d_readdata),
    .bus_error(bus_error),
    .mem_address(mem_address),
    .mem_byteenable(mem_byteenable),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata)
  );

  logic [7:0]  ram [MEMB];
  logic [7:0]  ref_mem [MEMB];
  logic [31:0] ram_q = '0;

  function automatic logic [31:0] lane_mask(logic [3:0] be);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
    return m;
  endfunction

  assign mem_readdata = ram_q & lane_mask(mem_byteenable);

  always @(posedge clk) begin
    if (mem_write)
      for (int k = 0; k < 4; k++)
        if (mem_byteenable[k])
          ram[mem_address[11:0] + 12'(k)] <= mem_writedata[8*k +: 8];
    if (mem_read)
      ram_q <= {ram[mem_address[11:0] + 12'd3],
                ram[mem_address[11:0] + 12'd2],
                ram[mem_address[11:0] + 12'd1],
                ram[mem_address[11:0]]};
  end

  int          passed = 0;
  int          total = 0;
  logic [31:0] last_i = '0;
  logic [31:0] last_d = '0;
  bit          mdl_last = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_word(logic [31:0] a,
                                           logic [3:0] be);
    logic [31:0] w;
    for (int k = 0; k < 4; k++)
      w[8*k +: 8] = be[k] ? ref_mem[a[11:0] + 12'(k)] : 8'h0;
    return w;
  endfunction

  task automatic xact(input bit port, input bit rd, input bit wr,
                      input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd);
    bit          iswr, oor, wq, done;
    logic [3:0]  ebe, sb;
    logic [31:0] sa, sw, expw;
    int          n, exp_lat, nrd, nwr, scyc;
    iswr = port & wr;
    oor = (longint'(a) + 3 >= MEMB);
    ebe = port ? be : 4'hf;
    exp_lat = oor ? 1 : (iswr ? 2 : 3);
    if (port) begin
      d_read = rd; d_write = wr; d_address = a;
      d_byteenable = be; d_writedata = wd;
    end else begin
      i_read = 1'b1; i_address = a;
    end
    n = 0; nrd = 0; nwr = 0; scyc = 0; done = 0;
    sa = '0; sb = '0; sw = '0;
    while (!done && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (mem_read | mem_write) begin
        scyc = n; sa = mem_address;
        sb = mem_byteenable; sw = mem_writedata;
      end
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      wq = port ? d_waitrequest : i_waitrequest;
      if (!wq) done = 1;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("bus_error", 32'(bus_error), 32'(oor));
    chk("rd_strobes", 32'(nrd), 32'(!oor && !iswr));
    chk("wr_strobes", 32'(nwr), 32'(!oor && iswr));
    if (!oor) begin
      chk("strobe_cycle", 32'(scyc), 32'd1);
      chk("mem_address", sa, a);
      chk("mem_be", 32'(sb), 32'(ebe));
      if (iswr) chk("mem_wdata", sw, wd);
    end
    mdl_last = port;
    if (iswr) begin
      if (!oor)
        for (int k = 0; k < 4; k++)
          if (be[k]) ref_mem[a[11:0] + 12'(k)] = wd[8*k +: 8];
    end else begin
      expw = oor ? 32'h0 : exp_word(a, ebe);
      if (port) last_d = expw;
      else last_i = expw;
    end
    chk("i_readdata", i_readdata, last_i);
    chk("d_readdata", d_readdata, last_d);
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int          cyc, lastc, ncomp;
    bit          expp, who;
    logic [31:0] cia, cda, expw, ra, rw;
    logic [3:0]  cdb, rb;
    int          sel, op;

    for (int k = 0; k < MEMB; k++) begin
      ram[k] = 8'($urandom);
      ref_mem[k] = ram[k];
    end
    {ram[3], ram[2], ram[1], ram[0]} = 32'h2408_0005;
    {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]} = 32'h2408_0005;

    #12;
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_i_readdata", i_readdata, 32'd0);
    chk("rst_d_readdata", d_readdata, 32'd0);
    chk("rst_bus_error", 32'(bus_error), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);

    xact(0, 1, 0, 32'h0, 4'hf, 32'h0);
    chk("fetch_word", i_readdata, 32'h2408_0005);
    xact(1, 0, 1, 32'h100, 4'hf, 32'hDEAD_BEEF);
    xact(1, 1, 0, 32'h100, 4'hf, 32'h0);
    chk("load_word", d_readdata, 32'hDEAD_BEEF);
    xact(1, 1, 0, 32'hFFE, 4'hf, 32'h0);
    xact(1, 1, 1, 32'h200, 4'b0001, 32'h0000_00AB);
    xact(1, 1, 0, 32'h200, 4'b0001, 32'h0);
    chk("rw_byte", d_readdata, 32'h0000_00AB);
    xact(1, 1, 0, 32'hFFC, 4'hf, 32'h0);
    xact(0, 1, 0, 32'hFFD, 4'hf, 32'h0);
    xact(1, 0, 1, 32'h300, 4'h0, 32'h1234_5678);
    xact(1, 1, 0, 32'h300, 4'h0, 32'h0);

    i_read = 1'b1; i_address = 32'h40;
    @(posedge clk); @(posedge clk); @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_mem_read", 32'(mem_read), 32'd0);
    chk("mid_rst_mem_address", mem_address, 32'd0);
    chk("mid_rst_mem_be", 32'(mem_byteenable), 32'd0);
    chk("mid_rst_mem_wdata", mem_writedata, 32'd0);
    chk("mid_rst_i_readdata", i_readdata, 32'd0);
    chk("mid_rst_d_readdata", d_readdata, 32'd0);
    chk("mid_rst_i_wait", 32'(i_waitrequest), 32'd1);
    last_i = '0; last_d = '0; mdl_last = 1'b1;
    i_read = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    xact(0, 1, 0, 32'h40, 4'hf, 32'h0);

    cia = 32'($urandom_range(0, MEMB - 4));
    cda = 32'($urandom_range(0, MEMB - 4));
    cdb = 4'($urandom);
    i_read = 1'b1; i_address = cia;
    d_read = 1'b1; d_address = cda; d_byteenable = cdb;
    expp = ~mdl_last;
    cyc = 0; lastc = 0; ncomp = 0;
    while (ncomp < 8 && cyc < 60) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (!i_waitrequest || !d_waitrequest) begin
        chk("single_done", 32'(!i_waitrequest && !d_waitrequest),
            32'd0);
        who = !d_waitrequest;
        chk("arb_order", 32'(who), 32'(expp));
        chk("arb_gap", 32'(cyc - lastc), ncomp == 0 ? 32'd3 : 32'd4);
        if (who) begin
          expw = exp_word(cda, cdb);
          chk("cont_d_readdata", d_readdata, expw);
          cda = 32'($urandom_range(0, MEMB - 4));
          cdb = 4'($urandom);
          d_address = cda; d_byteenable = cdb;
        end else begin
          expw = exp_word(cia, 4'hf);
          chk("cont_i_readdata", i_readdata, expw);
          cia = 32'($urandom_range(0, MEMB - 4));
          i_address = cia;
        end
        mdl_last = who;
        expp = ~who;
        lastc = cyc;
        ncomp++;
      end
    end
    chk("cont_count", 32'(ncomp), 32'd8);
    i_read = 1'b0; d_read = 1'b0;
    @(negedge clk);
    if (ncomp < 8) @(negedge clk);
    last_i = i_readdata;
    last_d = d_readdata;

    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7) ra = 32'($urandom_range(0, MEMB - 4));
      else if (sel == 7) ra = 32'(MEMB - 4);
      else if (sel == 8) ra = 32'(MEMB - 3);
      else ra = 32'hFFFF_FFFF;
      rb = 4'($urandom);
      rw = $urandom;
      op = int'($urandom_range(0, 3));
      if (op == 0) xact(0, 1, 0, ra, 4'hf, 32'h0);
      else if (op == 1) xact(1, 1, 0, ra, rb, 32'h0);
      else if (op == 2) xact(1, 0, 1, ra, rb, rw);
      else xact(1, 1, 1, ra, rb, rw);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
